program_loader: RTL and testbench

Writer side of the instruction memory: receives a framed program image as a byte stream (from an upstream serial receiver) and writes it word by word into the CPU's instruction memory through a synchronous write port. It holds the core stalled while loading and reports completion or checksum failure. It sits between the byte receiver and the write port of the instruction ROM/RAM that the program counter reads.

---
 rtl/program_loader_pkg.sv | 34 +++
 rtl/program_loader.sv | 207 ++++++++++++++++++++
 tb/tb_program_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared definitions for the program loader. Holds the loader
//               state encoding and the default frame start marker.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // State encoding
    localparam int         STATE_W      = 3;
    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_LEN_HI_ENC  = 3'd1;
    localparam logic [2:0] ST_LEN_LO_ENC  = 3'd2;
    localparam logic [2:0] ST_WORD_HI_ENC = 3'd3;
    localparam logic [2:0] ST_WORD_LO_ENC = 3'd4;
    localparam logic [2:0] ST_WRITE_ENC   = 3'd5;
    localparam logic [2:0] ST_CHK_ENC     = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_LEN_HI  = ST_LEN_HI_ENC,
        ST_LEN_LO  = ST_LEN_LO_ENC,
        ST_WORD_HI = ST_WORD_HI_ENC,
        ST_WORD_LO = ST_WORD_LO_ENC,
        ST_WRITE   = ST_WRITE_ENC,
        ST_CHK     = ST_CHK_ENC
    } loader_state_t;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a framed program image as a byte stream and writes
//               it word by word into the instruction memory write port. The
//               core is held while loading; completion is pulsed on o_done,
//               a bad frame raises the sticky o_error.
//               Frame: SYNC, LEN_HI, LEN_LO, LEN x (WORD_HI, WORD_LO), CHK.
// Ports       : i_clk        system clock
//               i_rst        asynchronous active-high reset
//               i_rx_valid   byte available on i_rx_data
//               i_rx_data    received byte
//               o_rx_ready   byte accepted when valid && ready
//               o_wr_en      instruction memory write strobe
//               o_wr_addr    write address
//               o_wr_data    write data (16 bit)
//               o_core_hold  core must not fetch while high
//               o_done       one-cycle pulse, image loaded and checksum good
//               o_error      sticky, last frame failed (checksum or length)
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [15:0]           o_wr_data,
    output logic                  o_core_hold,
    output logic                  o_done,
    output logic                  o_error
);

    // One extra address bit so a full 2^ADDR_WIDTH image can be counted
    localparam int          CNT_W       = ADDR_WIDTH + 1;
    localparam logic [16:0] C_MAX_WORDS = 17'(1) << ADDR_WIDTH;

    loader_state_t     r_state,     w_state_nxt;
    logic [15:0]       r_len,       w_len_nxt;
    logic [CNT_W-1:0]  r_addr,      w_addr_nxt;
    logic [7:0]        r_sum,       w_sum_nxt;
    logic [7:0]        r_hi,        w_hi_nxt;
    logic [15:0]       r_wr_data,   w_wr_data_nxt;
    logic              r_wr_en,     w_wr_en_nxt;
    logic              r_rx_ready,  w_rx_ready_nxt;
    logic              r_hold,      w_hold_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_error,     w_error_nxt;

    logic              w_xfer;
    logic [7:0]        w_sum_add;
    logic [CNT_W-1:0]  w_addr_inc;
    logic              w_last;
    logic [15:0]       w_len_full;

    assign w_xfer     = i_rx_valid & r_rx_ready;
    assign w_sum_add  = r_sum + i_rx_data;
    assign w_addr_inc = r_addr + CNT_W'(1);
    // Last word when the post-increment count reaches LEN
    assign w_last     = (17'(w_addr_inc) == {1'b0, r_len});
    assign w_len_full = {r_len[15:8], i_rx_data};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_addr     <= '0;
            r_sum      <= '0;
            r_hi       <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_rx_ready <= 1'b1;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_addr     <= w_addr_nxt;
            r_sum      <= w_sum_nxt;
            r_hi       <= w_hi_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_rx_ready <= w_rx_ready_nxt;
            r_hold     <= w_hold_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_addr_nxt    = r_addr;
        w_sum_nxt     = r_sum;
        w_hi_nxt      = r_hi;
        w_wr_data_nxt = r_wr_data;
        w_wr_en_nxt   = 1'b0;
        w_hold_nxt    = r_hold;
        w_done_nxt    = 1'b0;
        w_error_nxt   = r_error;

        case (r_state)
            ST_IDLE: begin
                // Anything other than the start marker is discarded
                if (w_xfer && (i_rx_data == SYNC_BYTE)) begin
                    w_error_nxt = 1'b0;
                    w_hold_nxt  = 1'b1;
                    w_addr_nxt  = '0;
                    w_sum_nxt   = '0;
                    w_state_nxt = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                if (w_xfer) begin
                    w_len_nxt   = {i_rx_data, r_len[7:0]};
                    w_sum_nxt   = w_sum_add;
                    w_state_nxt = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_len_nxt = w_len_full;
                    w_sum_nxt = w_sum_add;
                    if ({1'b0, w_len_full} > C_MAX_WORDS) begin
                        // Oversized image: hold stays high, memory untouched
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_len_full == 16'd0) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_state_nxt = ST_WORD_HI;
                    end
                end
            end

            ST_WORD_HI: begin
                if (w_xfer) begin
                    w_hi_nxt    = i_rx_data;
                    w_sum_nxt   = w_sum_add;
                    w_state_nxt = ST_WORD_LO;
                end
            end

            ST_WORD_LO: begin
                if (w_xfer) begin
                    w_wr_data_nxt = {r_hi, i_rx_data};
                    w_sum_nxt     = w_sum_add;
                    w_wr_en_nxt   = 1'b1;
                    w_state_nxt   = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // The strobe is already up for this cycle; advance address
                w_addr_nxt  = w_addr_inc;
                w_state_nxt = w_last ? ST_CHK : ST_WORD_HI;
            end

            ST_CHK: begin
                if (w_xfer) begin
                    w_sum_nxt = w_sum_add;
                    if (w_sum_add == 8'd0) begin
                        w_done_nxt = 1'b1;
                        w_hold_nxt = 1'b0;
                    end else begin
                        // Memory may hold a partial image: keep core held
                        w_error_nxt = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Ready is registered, so it is derived from the upcoming state
        w_rx_ready_nxt = (w_state_nxt != ST_WRITE);
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_addr[ADDR_WIDTH-1:0];
    assign o_wr_data   = r_wr_data;
    assign o_core_hold = r_hold;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Frames are built from
//               word lists; the expected write sequence, done/error/hold
//               outcome and checksum come from a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          core_hold;
    logic          done;
    logic          error;

    program_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_core_hold (core_hold),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  fq[$];
    logic [15:0] wq[$];
    logic [23:0] cap[$];
    logic [23:0] expq[$];
    int          done_cnt = 0;
    bit          model_err  = 1'b0;
    bit          model_hold = 1'b0;

    // Capture every write strobe and done pulse
    always @(negedge clk) begin
        if (wr_en === 1'b1) cap.push_back({wr_addr, wr_data});
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte transfer
    task automatic send(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) chk("ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic build_frame(input int len, input bit bad);
        logic [7:0] sum = 8'h00;
        logic [15:0] l16 = 16'(len);
        fq.delete();
        fq.push_back(8'hA5);
        fq.push_back(l16[15:8]);
        fq.push_back(l16[7:0]);
        sum = l16[15:8] + l16[7:0];
        if (len <= (1 << AW)) begin
            for (int i = 0; i < len; i++) begin
                fq.push_back(wq[i][15:8]);
                fq.push_back(wq[i][7:0]);
                sum = sum + wq[i][15:8] + wq[i][7:0];
            end
        end
        sum = 8'h00 - sum;
        if (bad) sum = sum + 8'h01;
        fq.push_back(sum);
    endtask

    task automatic run_frame(input int len, input bit bad, input int garbage);
        bit len_err = (len > (1 << AW));
        int d0;
        logic [7:0] g;
        chk("error_sticky", {31'd0, error}, {31'd0, model_err});
        chk("hold_level", {31'd0, core_hold}, {31'd0, model_hold});
        for (int i = 0; i < garbage; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send(g);
        end
        build_frame(len, bad);
        expq.delete();
        if (!len_err) for (int i = 0; i < len; i++) expq.push_back({8'(i), wq[i]});
        cap.delete();
        d0 = done_cnt;
        for (int k = 0; k < fq.size(); k++) begin
            send(fq[k]);
            if (k == 0) chk("hold_after_sync", {31'd0, core_hold}, 32'd1);
            if (k == 2 && len_err) begin
                chk("len_error", {31'd0, error}, 32'd1);
                chk("len_error_hold", {31'd0, core_hold}, 32'd1);
                break;
            end
            if (k >= 4 && k < 3 + 2 * len && (k % 2) == 0) begin
                chk("wr_en_timing", {31'd0, wr_en}, 32'd1);
                chk("wr_addr_timing", {24'd0, wr_addr}, 32'((k - 4) / 2 % (1 << AW)));
                chk("wr_data_timing", {16'd0, wr_data}, {16'd0, wq[(k - 4) / 2]});
            end
            if (k == fq.size() - 1) begin
                chk("done_after_chk", {31'd0, done}, {31'd0, !bad});
                chk("error_after_chk", {31'd0, error}, {31'd0, bad});
                chk("hold_after_chk", {31'd0, core_hold}, {31'd0, bad});
            end
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_err  = len_err || bad;
        model_hold = len_err || bad;
        chk("write_count", cap.size(), expq.size());
        for (int i = 0; i < expq.size() && i < cap.size(); i++)
            chk("write_entry", {8'd0, cap[i]}, {8'd0, expq[i]});
        chk("done_pulses", done_cnt - d0, (!len_err && !bad) ? 1 : 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        chk({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic two-word image
        wq = '{16'h1234, 16'hABCD};
        run_frame(2, 1'b0, 0);

        // Bad checksum, then recovery with a good frame
        run_frame(2, 1'b1, 0);
        run_frame(2, 1'b0, 0);

        // Empty image
        run_frame(0, 1'b0, 0);

        // Oversized length, then recovery
        run_frame(257, 1'b0, 0);
        wq = '{16'h0F0F};
        run_frame(1, 1'b0, 0);

        // Full-size image ending at the address wrap
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(16'($urandom()));
        run_frame(256, 1'b0, 0);

        // Leading garbage, sync value carried as data
        send(8'h00);
        send(8'hFF);
        send(8'h12);
        wq = '{16'hA5A5, 16'h00A5};
        run_frame(2, 1'b0, 0);

        // Reset mid-frame after second word's high byte
        wq = '{16'h1234, 16'h5678};
        build_frame(2, 1'b0);
        cap.delete();
        for (int k = 0; k < 6; k++) send(fq[k]);
        #2 rst = 1'b1;
        #1 check_reset_values("midreset");
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_err  = 1'b0;
        model_hold = 1'b0;
        @(negedge clk);
        chk("midreset_writes", cap.size(), 1);
        chk("midreset_entry", {8'd0, cap[0]}, {8'd0, 8'h00, 16'h1234});
        wq = '{16'hBEEF, 16'hCAFE, 16'h0001};
        run_frame(3, 1'b0, 0);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            int len = $urandom_range(0, 12);
            bit bad = ($urandom_range(0, 3) == 0);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(16'($urandom()));
            run_frame(len, bad, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_program_loader
`default_nettype wire
